// File: rtl/quad_store_rmw.sv
// quad_store_rmw: places a low-aligned store value big-endian at its byte offset in a
// 64-bit quad and commits it to a quad-only RAM port by read-modify-write.
// req_type encoding: 0=RAM_QUAD, 1=RAM_LONG, 2=RAM_WORD, 3=RAM_BYTE.
// Optional: define QUAD_STORE_FWD_EN for a one-entry store buffer that lets a
// sub-quad store to the last written quad skip the RAM read.
module quad_store_rmw #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_type,
  input  logic [63:0]       req_data,
  output logic [ADDR_W-4:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [63:0]       ram_rd_data,
  output logic              ram_wr_en,
  output logic [63:0]       ram_wr_data,
  output logic              done,
  output logic              err_align
);
  localparam logic [1:0] RAM_QUAD = 2'd0;
  localparam logic [1:0] RAM_LONG = 2'd1;
  localparam logic [1:0] RAM_WORD = 2'd2;
  localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_MERGE, S_WRITE, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-4:0] idx_q, idx_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        type_q, type_d;
  logic [63:0]       data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
`ifdef QUAD_STORE_FWD_EN
  logic              buf_v_q, buf_v_d;
  logic [ADDR_W-4:0] buf_idx_q, buf_idx_d;
  logic [63:0]       buf_data_q, buf_data_d;
`endif

  function automatic logic misaligned(input logic [1:0] t, input logic [2:0] o);
    return (t == RAM_QUAD) ? (o != 3'd0) : (t == RAM_LONG) ? (o[1:0] != 2'd0) :
           (t == RAM_WORD) ? o[0] : 1'b0;
  endfunction

  // Big-endian placement: the field is first pushed to the top of the quad, then
  // shifted down by the byte offset, so byte 0 of the address is bits [63:56].
  function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] val,
                                        input logic [1:0] t, input logic [2:0] o);
    logic [63:0] m, v;
    m = (t == RAM_QUAD) ? '1 : (t == RAM_LONG) ? {32'hFFFF_FFFF, 32'h0} :
        (t == RAM_WORD) ? {16'hFFFF, 48'h0} : {8'hFF, 56'h0};
    v = (t == RAM_QUAD) ? val : (t == RAM_LONG) ? {val[31:0], 32'h0} :
        (t == RAM_WORD) ? {val[15:0], 48'h0} : {val[7:0], 56'h0};
    return (base & ~(m >> {o, 3'b0})) | (v >> {o, 3'b0});
  endfunction

  // Next-state, request latching, merge and store-buffer update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    type_d  = type_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef QUAD_STORE_FWD_EN
    buf_v_d    = buf_v_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        idx_d  = req_addr[ADDR_W-1:3];
        off_d  = req_addr[2:0];
        type_d = req_type;
        data_d = req_data;
        if (misaligned(req_type, req_addr[2:0])) state_d = S_ERR;
        else if (req_type == RAM_QUAD) state_d = S_WRITE;
`ifdef QUAD_STORE_FWD_EN
        else if (buf_v_q && buf_idx_q == req_addr[ADDR_W-1:3]) begin
          data_d  = merge(buf_data_q, req_data, req_type, req_addr[2:0]);
          state_d = S_WRITE;
        end
`endif
        else state_d = S_READ;
      end
      S_READ: begin
        cnt_d   = WAIT_INIT;
        state_d = (RD_LATENCY > 1) ? S_WAIT : S_MERGE;
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd0) ? S_MERGE : S_WAIT;
      end
      S_MERGE: begin
        data_d  = merge(ram_rd_data, data_q, type_q, off_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef QUAD_STORE_FWD_EN
        buf_v_d    = 1'b1;
        buf_idx_d  = idx_q;
        buf_data_d = data_q;
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      type_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef QUAD_STORE_FWD_EN
      buf_v_q    <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      type_q  <= type_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef QUAD_STORE_FWD_EN
      buf_v_q    <= buf_v_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
`endif
    end
  end

  assign req_ready   = state_q == S_IDLE;
  assign ram_rd_en   = state_q == S_READ;
  assign ram_wr_en   = state_q == S_WRITE;
  assign done        = state_q == S_DONE;
  assign err_align   = state_q == S_ERR;
  assign ram_addr    = idx_q;
  assign ram_wr_data = ram_wr_en ? data_q : '0;
endmodule

// File: tb/tb_quad_store_rmw.sv
// tb_quad_store_rmw: directed vector table plus reset-abort and forwarding sequences
// against a small RAM model with RD_LATENCY=2.
module tb_quad_store_rmw;
  localparam int RL = 2;
  localparam logic [1:0] QUAD = 2'd0, LONG = 2'd1, WORD = 2'd2, BYTE = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_type;
  logic [63:0] req_data;
  logic [28:0] ram_addr;
  logic        ram_rd_en;
  logic [63:0] ram_rd_data;
  logic        ram_wr_en;
  logic [63:0] ram_wr_data;
  logic        done;
  logic        err_align;

  int errors = 0;
  int checks = 0;
  int wr_total = 0;

  logic [63:0] mem [0:15];
  logic [63:0] p0, p1;

  quad_store_rmw #(.ADDR_W(32), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type), .req_data(req_data),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .done(done), .err_align(err_align)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p0 <= ram_rd_en ? mem[ram_addr[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    p1 <= p0;
    if (ram_wr_en) begin
      mem[ram_addr[3:0]] <= ram_wr_data;
      wr_total <= wr_total + 1;
    end
  end
  assign ram_rd_data = p1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] t, input logic [63:0] d,
                          output int rds, output int wrs, output logic [28:0] widx,
                          output logic [63:0] wdat, output int lat, output logic errs);
    rds = 0; wrs = 0; widx = '0; wdat = '0; lat = 0; errs = 1'b0;
    @(negedge clk);
    chk("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_addr = a; req_type = t; req_data = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = ~a; req_type = ~t; req_data = ~d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_rd_en) rds++;
      if (ram_wr_en) begin
        wrs++;
        widx = ram_addr;
        wdat = ram_wr_data;
      end
      if (err_align) errs = 1'b1;
      if (done || err_align) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    chk("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [63:0] init;
    logic        err;
    int          rds;
    logic [63:0] wr;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int rds, wrs, lat;
    logic [28:0] widx;
    logic [63:0] wdat;
    logic errs;
    int wt;
    vecs[0]  = '{32'h13, BYTE, 64'hAB, 64'h0011223344556677, 1'b0, 1, 64'h001122AB44556677, 3 + RL};
    vecs[1]  = '{32'h36, WORD, 64'hBEEF, 64'h0011223344556677, 1'b0, 1, 64'h001122334455BEEF, 3 + RL};
    vecs[2]  = '{32'h40, LONG, 64'hDEADBEEF, 64'h0011223344556677, 1'b0, 1, 64'hDEADBEEF44556677, 3 + RL};
    vecs[3]  = '{32'h18, QUAD, 64'h0123456789ABCDEF, 64'h0, 1'b0, 0, 64'h0123456789ABCDEF, 2};
    vecs[4]  = '{32'h13, WORD, 64'h1234, 64'h0, 1'b1, 0, 64'h0, 1};
    vecs[5]  = '{32'h50, BYTE, 64'hFFFFFFFFFFFFFF5A, 64'h0011223344556677, 1'b0, 1, 64'h5A11223344556677, 3 + RL};
    vecs[6]  = '{32'h12, LONG, 64'h55555555, 64'h0, 1'b1, 0, 64'h0, 1};
    vecs[7]  = '{32'h1C, QUAD, 64'h1, 64'h0, 1'b1, 0, 64'h0, 1};
    vecs[8]  = '{32'h2C, LONG, 64'h11111111CAFEF00D, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1, 64'hFFFFFFFFCAFEF00D, 3 + RL};
    vecs[9]  = '{32'h20, WORD, 64'hA5A5, 64'h0, 1'b0, 1, 64'hA5A5000000000000, 3 + RL};
    vecs[10] = '{32'h0F, BYTE, 64'h77, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1, 64'hFFFFFFFFFFFFFF77, 3 + RL};
    vecs[11] = '{32'h62, WORD, 64'hFFFF1234, 64'h0, 1'b0, 1, 64'h0000123400000000, 3 + RL};

    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_type = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {59'd0, req_ready, ram_rd_en, ram_wr_en, done, err_align}, 64'h10);
    chk("reset_addr", {35'd0, ram_addr}, 64'd0);
    chk("reset_wdata", ram_wr_data, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      mem[vecs[i].addr[6:3]] = vecs[i].init;
      do_store(vecs[i].addr, vecs[i].typ, vecs[i].data, rds, wrs, widx, wdat, lat, errs);
      chk($sformatf("v%0d_err", i), {63'd0, errs}, {63'd0, vecs[i].err});
      chk($sformatf("v%0d_rds", i), 64'(rds), 64'(vecs[i].rds));
      chk($sformatf("v%0d_wrs", i), 64'(wrs), vecs[i].err ? 64'd0 : 64'd1);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      if (!vecs[i].err) begin
        chk($sformatf("v%0d_widx", i), {35'd0, widx}, {35'd0, vecs[i].addr[31:3]});
        chk($sformatf("v%0d_wdata", i), wdat, vecs[i].wr);
      end
    end

    // Reset asserted while waiting for read data: no write may follow
    @(negedge clk);
    mem[9] = 64'h0011223344556677;
    wt = wr_total;
    req_valid = 1'b1; req_addr = 32'h48; req_type = BYTE; req_data = 64'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_read_strobe", {63'd0, ram_rd_en}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {59'd0, req_ready, ram_rd_en, ram_wr_en, done, err_align}, 64'h10);
    chk("rst_addr", {35'd0, ram_addr}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_write", 64'(wr_total - wt), 64'd0);
    chk("rst_mem_kept", mem[9], 64'h0011223344556677);

    // Two byte stores into the same quad: second one may forward from the buffer
    @(negedge clk);
    mem[7] = 64'h0011223344556677;
    do_store(32'h38, BYTE, 64'hAA, rds, wrs, widx, wdat, lat, errs);
    chk("fwd1_rds", 64'(rds), 64'd1);
    chk("fwd1_wdata", wdat, 64'hAA11223344556677);
    do_store(32'h39, BYTE, 64'hBB, rds, wrs, widx, wdat, lat, errs);
`ifdef QUAD_STORE_FWD_EN
    chk("fwd2_rds", 64'(rds), 64'd0);
    chk("fwd2_lat", 64'(lat), 64'd2);
`else
    chk("fwd2_rds", 64'(rds), 64'd1);
    chk("fwd2_lat", 64'(lat), 64'(3 + RL));
`endif
    chk("fwd2_wdata", wdat, 64'hAABB223344556677);
    chk("fwd2_mem", mem[7], 64'hAABB223344556677);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
